// File: rtl/sdram_arb_pkg.sv
// Shared encodings and constants for the SDRAM request arbiter.
// State codes, the memory-mapped window tag and the default controller sequence length.
package sdram_arb_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  localparam logic [1:0] MMIO_TAG       = 2'b10;
  localparam int         SEQ_CYCLES_DEF = 5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_DONE  = ST_DONE,
    S_ERR   = ST_ERR
  } arb_state_e;

  // Only the top two address bits select the SDRAM window.
  function automatic logic addr_in_window(input logic [31:0] addr);
    return addr[31:30] == MMIO_TAG;
  endfunction

endpackage

// File: rtl/sdram_req_arbiter_if.sv
// Requester, controller and status signals of the SDRAM request arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface sdram_req_arbiter_if;

  logic        in_req0;
  logic        in_req1;
  logic        in_wr0;
  logic        in_wr1;
  logic [31:0] in_addr0;
  logic [31:0] in_addr1;
  logic [31:0] in_wdata0;
  logic [31:0] in_wdata1;
  logic        out_ack0;
  logic        out_ack1;
  logic        out_err0;
  logic        out_err1;
  logic [31:0] out_rdata0;
  logic [31:0] out_rdata1;
  logic        out_HSEL;
  logic        out_HWRITE;
  logic [31:0] out_HADDR;
  logic [31:0] out_HWDATA;
  logic        in_HREADY;
  logic [31:0] in_HRDATA;
  logic        out_grant;
  logic        out_busy;

  modport slave (
    input  in_req0, in_req1, in_wr0, in_wr1, in_addr0, in_addr1,
           in_wdata0, in_wdata1, in_HREADY, in_HRDATA,
    output out_ack0, out_ack1, out_err0, out_err1, out_rdata0, out_rdata1,
           out_HSEL, out_HWRITE, out_HADDR, out_HWDATA, out_grant, out_busy
  );

  modport master (
    output in_req0, in_req1, in_wr0, in_wr1, in_addr0, in_addr1,
           in_wdata0, in_wdata1, in_HREADY, in_HRDATA,
    input  out_ack0, out_ack1, out_err0, out_err1, out_rdata0, out_rdata1,
           out_HSEL, out_HWRITE, out_HADDR, out_HWDATA, out_grant, out_busy
  );

endinterface

// File: rtl/sdram_rr_pick.sv
// Combinational two-way pick between the CPU and DMA request lines.
// SDRAM_ARB_FIXED_PRIO_EN makes port 0 always win and leaves the pointer input unused.
module sdram_rr_pick (
  input  logic req0_i,
  input  logic req1_i,
  input  logic ptr_i,
  output logic valid_o,
  output logic winner_o
);

  assign valid_o = req0_i | req1_i;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ptr_i;
  assign winner_o   = ~req0_i & req1_i;
`else
  assign winner_o   = (req0_i & req1_i) ? ptr_i : req1_i;
`endif

endmodule

// File: rtl/sdram_req_arbiter.sv
// Two-port arbiter and command sequencer in front of the single-port SDRAM controller.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module sdram_req_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int SEQ_CYCLES = SEQ_CYCLES_DEF,
  parameter int CNT_W      = 4
) (
  input logic               in_HCLK,
  input logic               in_HRESET,
  sdram_req_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEQ_CYCLES - 1);

  arb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             grant_q;
  logic             hwrite_q;
  logic [31:0]      haddr_q;
  logic [31:0]      hwdata_q;
  logic             ack0_q, ack1_q;
  logic             err0_q, err1_q;
  logic [31:0]      rdata0_q, rdata1_q;
  logic             ptr_d;

  logic             pick_valid;
  logic             pick_winner;
  logic             win_wr;
  logic [31:0]      win_addr;
  logic [31:0]      win_wdata;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  assign ptr_d = 1'b0;
`else
  logic ptr_q;
  assign ptr_d = ptr_q;
`endif

  sdram_rr_pick u_pick (
    .req0_i   (bus.in_req0),
    .req1_i   (bus.in_req1),
    .ptr_i    (ptr_d),
    .valid_o  (pick_valid),
    .winner_o (pick_winner)
  );

  assign win_wr    = pick_winner ? bus.in_wr1    : bus.in_wr0;
  assign win_addr  = pick_winner ? bus.in_addr1  : bus.in_addr0;
  assign win_wdata = pick_winner ? bus.in_wdata1 : bus.in_wdata0;

  always_ff @(posedge in_HCLK or posedge in_HRESET) begin
    if (in_HRESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      grant_q  <= 1'b0;
      hwrite_q <= 1'b0;
      haddr_q  <= '0;
      hwdata_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      ptr_q    <= 1'b0;
`endif
    end else begin
      // Acks and errors are single-cycle pulses unless re-armed below.
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_valid) begin
            grant_q  <= pick_winner;
            hwrite_q <= win_wr;
            haddr_q  <= win_addr;
            hwdata_q <= win_wdata;
            if (addr_in_window(win_addr)) begin
              state_q <= S_ISSUE;
            end else begin
              // Decode errors are acknowledged straight away; SDRAM is never selected.
              state_q <= S_ERR;
              if (pick_winner) begin
                ack1_q <= 1'b1;
                err1_q <= 1'b1;
              end else begin
                ack0_q <= 1'b1;
                err0_q <= 1'b1;
              end
            end
          end
        end
        S_ISSUE: begin
          if (bus.in_HREADY) begin
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            if (!hwrite_q) begin
              if (grant_q) rdata1_q <= bus.in_HRDATA;
              else         rdata0_q <= bus.in_HRDATA;
            end
            if (grant_q) ack1_q <= 1'b1;
            else         ack0_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE, S_ERR: begin
`ifndef SDRAM_ARB_FIXED_PRIO_EN
          ptr_q   <= ~grant_q;
`endif
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The select depends on this cycle's ready, so it cannot be registered ahead of time.
  assign bus.out_HSEL   = (state_q == S_ISSUE) && bus.in_HREADY;
  assign bus.out_busy   = (state_q != S_IDLE);
  assign bus.out_grant  = grant_q;
  assign bus.out_HWRITE = hwrite_q;
  assign bus.out_HADDR  = haddr_q;
  assign bus.out_HWDATA = hwdata_q;
  assign bus.out_ack0   = ack0_q;
  assign bus.out_ack1   = ack1_q;
  assign bus.out_err0   = err0_q;
  assign bus.out_err1   = err1_q;
  assign bus.out_rdata0 = rdata0_q;
  assign bus.out_rdata1 = rdata1_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed bench for sdram_req_arbiter: single-port vector table, round-robin burst,
// ready stall and asynchronous reset abort.
module tb_sdram_req_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_req_arbiter_if bus ();

  sdram_req_arbiter dut (
    .in_HCLK   (clk),
    .in_HRESET (rst),
    .bus       (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    int          port;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] hrdata;
    int          stall;
    logic        exp_err;
    int          exp_sel;
    int          exp_ack;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  // One transaction from an idle arbiter; cycle 0 is the first cycle the request is visible.
  task automatic run_txn(input vec_t v, input string tag);
    int          sel_cyc = -1;
    int          ack_cyc = -1;
    logic        got_err = 1'b0;
    logic        got_grant = 1'b0;
    logic        other_ack = 1'b0;
    logic [31:0] other_rdata;
    @(posedge clk); #1;
    other_rdata = (v.port == 0) ? bus.out_rdata1 : bus.out_rdata0;
    if (v.port == 0) begin
      bus.in_req0 = 1'b1; bus.in_wr0 = v.wr; bus.in_addr0 = v.addr; bus.in_wdata0 = v.wdata;
      bus.in_addr1 = ~v.addr; bus.in_wdata1 = ~v.wdata; bus.in_wr1 = ~v.wr;
    end else begin
      bus.in_req1 = 1'b1; bus.in_wr1 = v.wr; bus.in_addr1 = v.addr; bus.in_wdata1 = v.wdata;
      bus.in_addr0 = ~v.addr; bus.in_wdata0 = ~v.wdata; bus.in_wr0 = ~v.wr;
    end
    for (int k = 0; k < 40; k++) begin
      bus.in_HREADY = (k >= 1 && k <= v.stall) ? 1'b0 : 1'b1;
      bus.in_HRDATA = (k == 6 + v.stall) ? v.hrdata : (32'h0BAD_0000 | 32'(k));
      @(negedge clk);
      if (bus.out_HSEL && sel_cyc < 0) sel_cyc = k;
      if ((v.port == 0) ? bus.out_ack1 : bus.out_ack0) other_ack = 1'b1;
      if ((v.port == 0) ? bus.out_ack0 : bus.out_ack1) begin
        ack_cyc   = k;
        got_err   = (v.port == 0) ? bus.out_err0 : bus.out_err1;
        got_grant = bus.out_grant;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.in_req0   = 1'b0;
    bus.in_req1   = 1'b0;
    bus.in_HREADY = 1'b1;
    $display("txn %s port=%0d wr=%0b addr=%h sel_cycle=%0d ack_cycle=%0d err=%0b",
             tag, v.port, v.wr, v.addr, sel_cyc, ack_cyc, got_err);
    check({tag, "_ack_cycle"}, 32'(ack_cyc), 32'(v.exp_ack));
    check({tag, "_sel_cycle"}, 32'(sel_cyc), 32'(v.exp_sel));
    check({tag, "_err"}, got_err, v.exp_err);
    check({tag, "_grant"}, got_grant, 32'(v.port));
    check({tag, "_other_ack"}, other_ack, 0);
    check({tag, "_haddr"}, bus.out_HADDR, v.addr);
    check({tag, "_hwrite"}, bus.out_HWRITE, v.wr);
    check({tag, "_hwdata"}, bus.out_HWDATA, v.wdata);
    check({tag, "_rdata"}, (v.port == 0) ? bus.out_rdata0 : bus.out_rdata1, v.exp_rdata);
    check({tag, "_other_rdata"}, (v.port == 0) ? bus.out_rdata1 : bus.out_rdata0, other_rdata);
    check({tag, "_busy_after"}, bus.out_busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int last;
    int idx;
    int exp_g[4];
    vec_t v_err;

    vecs[0] = '{0, 1'b0, 32'h8001_4005, 32'h0000_0000, 32'hDEAD_BEEF, 0, 1'b0,  1,  7, 32'hDEAD_BEEF};
    vecs[1] = '{1, 1'b1, 32'h8000_0003, 32'h1234_5678, 32'h5555_AAAA, 0, 1'b0,  1,  7, 32'h0000_0000};
    vecs[2] = '{0, 1'b0, 32'h4000_0000, 32'h0000_0000, 32'h1111_1111, 0, 1'b1, -1,  1, 32'hDEAD_BEEF};
    vecs[3] = '{1, 1'b0, 32'h8ABC_0010, 32'h0000_0000, 32'hCAFE_F00D, 0, 1'b0,  1,  7, 32'hCAFE_F00D};
    vecs[4] = '{0, 1'b1, 32'hBFFF_FFFC, 32'hA5A5_5A5A, 32'h7777_7777, 0, 1'b0,  1,  7, 32'hDEAD_BEEF};
    vecs[5] = '{1, 1'b0, 32'hC000_0000, 32'h0000_0000, 32'h2222_2222, 0, 1'b1, -1,  1, 32'hCAFE_F00D};
    vecs[6] = '{0, 1'b0, 32'h8000_0100, 32'h0000_0000, 32'h0F0F_1234, 3, 1'b0,  4, 10, 32'h0F0F_1234};
    vecs[7] = '{1, 1'b1, 32'h0000_0000, 32'hFFFF_0000, 32'h3333_3333, 0, 1'b1, -1,  1, 32'hCAFE_F00D};

    bus.in_req0 = 0; bus.in_req1 = 0; bus.in_wr0 = 0; bus.in_wr1 = 0;
    bus.in_addr0 = 0; bus.in_addr1 = 0; bus.in_wdata0 = 0; bus.in_wdata1 = 0;
    bus.in_HREADY = 1'b1; bus.in_HRDATA = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", bus.out_busy, 0);
    check("reset_hsel", bus.out_HSEL, 0);
    check("reset_acks", {bus.out_ack0, bus.out_ack1, bus.out_err0, bus.out_err1}, 0);
    check("reset_grant", bus.out_grant, 0);
    check("reset_haddr", bus.out_HADDR, 0);
    check("reset_rdata0", bus.out_rdata0, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Both ports held: grants alternate (or stay on port 0 with fixed priority), 8 cycles apart.
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    @(posedge clk); #1;
    bus.in_req0 = 1; bus.in_wr0 = 0; bus.in_addr0 = 32'h8000_1000;
    bus.in_req1 = 1; bus.in_wr1 = 0; bus.in_addr1 = 32'h8000_2000;
    bus.in_HREADY = 1; bus.in_HRDATA = 32'h5A5A_0000;
    acks = 0;
    last = -1;
    for (int k = 0; k < 80 && acks < 4; k++) begin
      @(negedge clk);
      if (bus.out_ack0 || bus.out_ack1) begin
        idx = bus.out_ack1 ? 1 : 0;
        $display("txn rr%0d ack_port=%0d grant=%0d cycle=%0d", acks, idx, bus.out_grant, k);
        check("rr_ack_port", 32'(idx), 32'(exp_g[acks]));
        check("rr_grant", bus.out_grant, 32'(exp_g[acks]));
        check("rr_both_acks", bus.out_ack0 & bus.out_ack1, 0);
        check("rr_spacing", 32'((acks == 0) ? k : k - last), 32'((acks == 0) ? 7 : 8));
        last = k;
        acks++;
      end
      @(posedge clk); #1;
    end
    bus.in_req0 = 0;
    bus.in_req1 = 0;
    check("rr_ack_count", 32'(acks), 4);

    // Port 0 decode error leaves the round-robin pointer on port 1.
    v_err = '{0, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'h0, 0, 1'b1, -1, 1, 32'h5A5A_0000};
    run_txn(v_err, "pre_reset_err");

    // Reset during a port 1 read aborts it and returns the pointer to port 0.
    @(posedge clk); #1;
    bus.in_req1 = 1; bus.in_wr1 = 0; bus.in_addr1 = 32'h8000_3000; bus.in_HRDATA = 32'h7E7E_7E7E;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_before", bus.out_busy, 1);
    #2 rst = 1'b1;
    #1;
    bus.in_req1 = 0;
    check("abort_busy", bus.out_busy, 0);
    check("abort_hsel", bus.out_HSEL, 0);
    check("abort_haddr", bus.out_HADDR, 0);
    check("abort_hwdata_hwrite_grant", {bus.out_HWDATA[0], bus.out_HWRITE, bus.out_grant}, 0);
    check("abort_acks", {bus.out_ack0, bus.out_ack1, bus.out_err0, bus.out_err1}, 0);
    check("abort_rdata0", bus.out_rdata0, 0);
    check("abort_rdata1", bus.out_rdata1, 0);
    #3 rst = 1'b0;
    acks = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.out_ack0 || bus.out_ack1 || bus.out_busy) acks++;
    end
    $display("txn abort idle_activity=%0d", acks);
    check("abort_no_ack", 32'(acks), 0);

    @(posedge clk); #1;
    bus.in_req0 = 1; bus.in_addr0 = 32'h8000_4000; bus.in_wr0 = 0;
    bus.in_req1 = 1; bus.in_addr1 = 32'h8000_5000; bus.in_wr1 = 0;
    last = -1;
    idx = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.out_ack0 || bus.out_ack1) begin
        idx  = bus.out_ack1 ? 1 : 0;
        last = k;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.in_req0 = 0;
    bus.in_req1 = 0;
    $display("txn post_reset ack_port=%0d ack_cycle=%0d", idx, last);
    check("post_reset_port", 32'(idx), 0);
    check("post_reset_ack_cycle", 32'(last), 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_req_arbiter.md
Name: sdram_req_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port SDRAM command controller, on the same in_HCLK domain.
- Accepts a held request from port 0 (CPU) or port 1 (DMA) and issues a one-cycle select with address, data and write flag to the controller.
- Counts out the controller's fixed command sequence (ACT, NOP, CAS, NOP, NOP), captures read data, and returns a one-cycle ack to the winning requester.
- Rejects addresses outside the memory-mapped window (addr[31:30] != 2'b10) with an error ack, without touching SDRAM.

Parameters:
- SEQ_CYCLES, 5: controller command-sequence length in cycles; legal range 2..15.
- CNT_W, 4: width of the sequence counter; must hold SEQ_CYCLES-1.
- MMIO_TAG, 2'b10: required value of addr[31:30].

Ports:
- in_HCLK  input  1  clock
- in_HRESET  input  1  reset; asynchronous, active-high
- in_req0 / in_req1  input  1  request, held until the matching ack
- in_wr0 / in_wr1  input  1  1 = write, 0 = read; stable while req is high
- in_addr0 / in_addr1  input  32  address; stable while req is high
- in_wdata0 / in_wdata1  input  32  write data; stable while req is high
- out_ack0 / out_ack1  output  1  one-cycle completion pulse
- out_err0 / out_err1  output  1  valid with ack; 1 = address decode error
- out_rdata0 / out_rdata1  output  32  read data, valid with ack on reads
- out_HSEL  output  1  one-cycle select to the controller
- out_HWRITE  output  1  latched write flag of the winner
- out_HADDR  output  32  latched address of the winner
- out_HWDATA  output  32  latched write data of the winner
- in_HREADY  input  1  controller idle/ready
- in_HRDATA  input  32  controller read data
- out_grant  output  1  index of the current or last winner
- out_busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, any state): all outputs go to 0; state = IDLE; RR pointer = 0; counter = 0.
- A reset mid-transaction aborts it: no ack is issued, out_HSEL drops immediately, and the requester must re-request.
- States: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE, no request: remain in IDLE.
- IDLE, any request: select the winner.
  - One request: that port wins.
  - Both requests: the port equal to the RR pointer wins.
  - Latch the winner's addr, wdata, wr and index into out_HADDR, out_HWDATA, out_HWRITE and out_grant.
  - If addr[31:30] == MMIO_TAG, go to ISSUE; otherwise go to ERR.
- ISSUE:
  - in_HREADY = 1: drive out_HSEL = 1 for exactly this cycle, clear the counter, go to WAIT.
  - in_HREADY = 0: out_HSEL = 0; remain in ISSUE.
- WAIT:
  - Increment the counter each cycle.
  - On the cycle where counter == SEQ_CYCLES-1: register in_HRDATA into that port's rdata if out_HWRITE = 0, then go to DONE.
- DONE:
  - Drive out_ackN = 1 and out_errN = 0 for one cycle.
  - RR pointer = ~out_grant.
  - Go to IDLE.
- ERR:
  - Drive out_ackN = 1 and out_errN = 1 for one cycle.
  - out_rdataN is unchanged and out_HSEL is never asserted.
  - RR pointer = ~out_grant.
  - Go to IDLE.
- Latency with in_HREADY = 1: request seen in IDLE at T0, out_HSEL at T1, ack at T(2+SEQ_CYCLES); T7 at the default.
  - Error ack at T1.
  - The next grant is evaluated at T(3+SEQ_CYCLES) at the earliest, so there is one IDLE cycle between transactions.
- Requester rules:
  - A requester may deassert req the cycle after its ack.
  - A req still high in the IDLE cycle after the ack is a new request.
  - A req dropped before its ack is a protocol violation; the arbiter still completes the transaction.
- out_HADDR, out_HWDATA and out_HWRITE hold their value until the next grant.
- out_rdataN holds its value between reads; on writes it is unchanged.
- The loser's req is ignored until IDLE and is never lost if it stays high.
- With both ports continuously requesting, grants alternate 0,1,0,1.

Optional Feature:
- SDRAM_ARB_FIXED_PRIO_EN defined: port 0 always wins simultaneous requests, and the RR pointer is not implemented; port 1 can starve.
- Undefined (default): round-robin as described above.

Decomposition:
- Package sdram_arb_pkg holds:
  - the state encoding localparams (IDLE=0, ISSUE=1, WAIT=2, DONE=3, ERR=4, 3 bits);
  - MMIO_TAG;
  - the default SEQ_CYCLES.
- Sub-module sdram_rr_pick: combinational 2-way pick from (req0, req1, ptr), producing a valid flag and a winner index; it honours SDRAM_ARB_FIXED_PRIO_EN.
- The FSM, counter and latches stay in the top level.

Test Plan:
1. Reset, then read port 0 with addr 32'h8001_4005 and in_HRDATA = 32'hDEAD_BEEF at T6 -> out_HSEL at T1 with out_HADDR = 32'h8001_4005 and out_HWRITE = 0; out_ack0 at T7; out_rdata0 = 32'hDEAD_BEEF; out_err0 = 0.
2. Write port 1 with addr 32'h8000_0003 and wdata 32'h1234_5678 -> out_HWRITE = 1 and out_HWDATA = 32'h1234_5678 at T1; out_ack1 at T7; out_rdata1 unchanged.
3. req0 and req1 raised together and held for 4 transactions -> out_grant sequence 0,1,0,1; ack spacing SEQ_CYCLES+3 = 8 cycles. With SDRAM_ARB_FIXED_PRIO_EN defined -> 0,0,0,0.
4. Port 0 addr 32'h4000_0000 -> out_ack0 = 1 and out_err0 = 1 at T1; out_HSEL never asserted; out_rdata0 unchanged.
5. in_HREADY held at 0 for 3 cycles after the grant -> out_HSEL stays 0 and is asserted at T4; ack at T10.
6. in_HRESET pulsed at T3 of a read -> all outputs are 0 asynchronously, no ack is ever issued, and the next request is granted to port 0.
